// File: rtl/range_sweep.sv
// Range sweeper: turns a range code into four ascending data beats.
// Optional saturating error counter port under RANGE_SWEEP_ERRCNT_EN.
module range_sweep #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           code_in,
  input  logic                 code_valid,
  output logic                 code_ready,
  output logic [3:0]           data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 data_last,
  output logic                 err
`ifdef RANGE_SWEEP_ERRCNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  typedef enum logic {
    IDLE,
    SWEEP
  } state_e;

  state_e     state_q;
  logic [3:0] base_q;
  logic [1:0] idx_q;
  logic [3:0] data_q;
  logic       valid_q;
  logic       last_q;
  logic       err_q;

  logic       code_ok;
  logic [1:0] code_m1;
  logic [3:0] base_new;
  logic [1:0] idx_nxt;

  // Codes 1..4 map onto base 0,4,8,12; code 4 wraps 2'b00-1 to 2'b11.
  assign code_ok  = (code_in != 3'd0) && (code_in < 3'd5);
  assign code_m1  = code_in[1:0] - 2'd1;
  assign base_new = {code_m1, 2'b00};
  assign idx_nxt  = idx_q + 2'd1;

`ifdef RANGE_SWEEP_ERRCNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      base_q    <= 4'd0;
      idx_q     <= 2'd0;
      data_q    <= 4'd0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef RANGE_SWEEP_ERRCNT_EN
      err_cnt_q <= '0;
`endif
    end else begin
      err_q <= 1'b0;
      unique case (1'b1)
        (state_q == IDLE): begin
          if (code_valid) begin
            if (code_ok) begin
              state_q <= SWEEP;
              base_q  <= base_new;
              idx_q   <= 2'd0;
              data_q  <= base_new;
              valid_q <= 1'b1;
              last_q  <= 1'b0;
            end else begin
              err_q <= 1'b1;
`ifdef RANGE_SWEEP_ERRCNT_EN
              if (err_cnt_q != {ERR_CNT_W{1'b1}})
                err_cnt_q <= err_cnt_q + 1'b1;
`endif
            end
          end
        end
        (state_q == SWEEP): begin
          if (data_ready) begin
            if (idx_q == 2'd3) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
            end else begin
              idx_q   <= idx_nxt;
              data_q  <= base_q + {2'b00, idx_nxt};
              last_q  <= (idx_nxt == 2'd3);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign code_ready = (state_q == IDLE);
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign data_last  = last_q;
  assign err        = err_q;

endmodule

// File: tb/tb_range_sweep.sv
// Directed bench for range_sweep with an expected-beat queue.
// Build with RANGE_SWEEP_ERRCNT_EN to also check err_cnt at width 2.
module tb_range_sweep;

`ifdef RANGE_SWEEP_ERRCNT_EN
  localparam int W = 2;
`else
  localparam int W = 8;
`endif

  logic         clk;
  logic         rst_n;
  logic [2:0]   code_in;
  logic         code_valid;
  logic         code_ready;
  logic [3:0]   data_out;
  logic         data_valid;
  logic         data_ready;
  logic         data_last;
  logic         err;
`ifdef RANGE_SWEEP_ERRCNT_EN
  logic [W-1:0] err_cnt;
`endif

  range_sweep #(.ERR_CNT_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code_in    (code_in),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data_last  (data_last),
`ifdef RANGE_SWEEP_ERRCNT_EN
    .err_cnt    (err_cnt),
`endif
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    logic       l;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_err = 1'b0;
  int   exp_cnt = 0;
  logic [2:0] last_acc_code;
  bit   last_acc;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit         xfer;
    bit         acc;
    logic [2:0] c;
    exp_t       e;
    xfer = data_valid && data_ready;
    acc  = code_valid && code_ready;
    c    = code_in;
    if (xfer) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", data_out, 4'hx);
      end else begin
        e = exp_q.pop_front();
        chk("data_out", data_out, e.d);
        chk("data_last", data_last, e.l);
      end
    end
    @(posedge clk);
    #1;
    last_acc = acc;
    last_acc_code = c;
    if (acc) begin
      if (c >= 3'd1 && c <= 3'd4) begin
        for (int k = 0; k < 4; k++) begin
          e.d = 4'((int'(c) - 1) * 4 + k);
          e.l = (k == 3);
          exp_q.push_back(e);
        end
      end else begin
        exp_err = 1'b1;
        if (exp_cnt < (1 << W) - 1) exp_cnt++;
      end
    end
    chk("err", err, exp_err);
    chk("data_valid", data_valid, (exp_q.size() != 0));
    chk("code_ready", code_ready, (exp_q.size() == 0));
`ifdef RANGE_SWEEP_ERRCNT_EN
    chk("err_cnt", err_cnt, W'(exp_cnt));
`endif
    exp_err = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < max_cycles) begin
      tick();
      i++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    code_in    = 3'd0;
    code_valid = 1'b0;
    data_ready = 1'b0;
    #12;
    chk("rst_data_valid", data_valid, 1'b0);
    chk("rst_data_out", data_out, 4'd0);
    chk("rst_data_last", data_last, 1'b0);
    chk("rst_err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_code_ready", code_ready, 1'b1);

    data_ready = 1'b1;
    code_in    = 3'd3;
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    chk("c3_first", data_out, 4'd8);
    chk("c3_latency", data_valid, 1'b1);
    tick();
    chk("c3_second", data_out, 4'd9);
    tick();
    chk("c3_third", data_out, 4'd10);
    chk("c3_last_early", data_last, 1'b0);
    tick();
    chk("c3_fourth", data_out, 4'd11);
    chk("c3_last", data_last, 1'b1);
    tick();
    chk("c3_done", exp_q.size(), 0);

    code_in    = 3'd1;
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    tick();
    data_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("c1_hold_val", data_out, 4'd1);
      chk("c1_hold_vld", data_valid, 1'b1);
    end
    data_ready = 1'b1;
    drain(10);

    code_in    = 3'd6;
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    chk("inv_err_pulse", err, 1'b1);
    tick();
    chk("inv_err_clear", err, 1'b0);

    code_valid = 1'b1;
    code_in = 3'd0; tick();
    code_in = 3'd5; tick();
    code_in = 3'd7; tick();
    code_in = 3'd0; tick();
    code_valid = 1'b0;
    tick();

    code_in    = 3'd4;
    code_valid = 1'b1;
    tick();
    code_in = 3'd2;
    begin
      int guard;
      guard = 0;
      do begin
        tick();
        guard++;
      end while (!(last_acc && last_acc_code == 3'd2) && guard < 20);
      chk("c42_accept_timeout", (guard < 20), 1'b1);
    end
    code_valid = 1'b0;
    chk("c2_first", data_out, 4'd4);
    drain(10);

    code_in    = 3'd2;
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    tick();
    tick();
    chk("c2_pre_rst", data_out, 4'd6);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", data_valid, 1'b0);
    chk("mid_rst_data", data_out, 4'd0);
    exp_q.delete();
    exp_cnt = 0;
    #15;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_code_ready", code_ready, 1'b1);
    for (int i = 0; i < 4; i++) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
